// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA pixel path: active-area size,
// background pattern codes and the 4:4:4 colour word.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  typedef enum logic [1:0] {
    PAT_BLACK = 2'b00,
    PAT_BARS  = 2'b01,
    PAT_GRAD  = 2'b10,
    PAT_CHECK = 2'b11
  } pat_e;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444;

endpackage

// File: rtl/vga_box_motion.sv
// Bouncing-box position state: moves STEP pixels per frame tick on each axis,
// clamping to the wall and reversing direction when a wall is reached.
module vga_box_motion #(
  parameter int BOX_SIZE = 32,
  parameter int STEP     = 2,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  output logic [9:0] box_x,
  output logic [8:0] box_y
);

  localparam logic [10:0] XLIM = 11'(H_ACTIVE - BOX_SIZE);
  localparam logic [9:0]  YLIM = 10'(V_ACTIVE - BOX_SIZE);

  logic        dir_x;
  logic        dir_y;
  logic [10:0] sum_x;
  logic [9:0]  sum_y;

  // One bit of headroom so the forward step can never wrap past the wall test.
  assign sum_x = {1'b0, box_x} + 11'(STEP);
  assign sum_y = {1'b0, box_y} + 10'(STEP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      box_x <= '0;
      dir_x <= 1'b1;
    end else if (frame_tick) begin
      if (dir_x && (sum_x >= XLIM)) begin
        box_x <= XLIM[9:0];
        dir_x <= 1'b0;
      end else if (!dir_x && (box_x <= 10'(STEP))) begin
        box_x <= '0;
        dir_x <= 1'b1;
      end else if (dir_x) begin
        box_x <= sum_x[9:0];
      end else begin
        box_x <= box_x - 10'(STEP);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      box_y <= '0;
      dir_y <= 1'b1;
    end else if (frame_tick) begin
      if (dir_y && (sum_y >= YLIM)) begin
        box_y <= YLIM[8:0];
        dir_y <= 1'b0;
      end else if (!dir_y && (box_y <= 9'(STEP))) begin
        box_y <= '0;
        dir_y <= 1'b1;
      end else if (dir_y) begin
        box_y <= sum_y[8:0];
      end else begin
        box_y <= box_y - 9'(STEP);
      end
    end
  end

endmodule

// File: rtl/vga_box_renderer.sv
// Pixel stage behind VGA_Driver: background pattern with a bouncing box on top,
// two-cycle pipeline with HSync/VSync delayed to stay aligned with RGB.
module vga_box_renderer
  import vga_pkg::*;
#(
  parameter int          BOX_SIZE = 32,
  parameter int          STEP     = 2,
  parameter logic [11:0] BOX_RGB  = 12'hFFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       HSync_in,
  input  logic       VSync_in,
  input  logic       blanking,
  input  logic [9:0] x,
  input  logic [8:0] y,
  input  logic [1:0] pattern,
  output logic [3:0] vgaRed,
  output logic [3:0] vgaGreen,
  output logic [3:0] vgaBlue,
  output logic       HSync,
  output logic       VSync
);

  logic       vs_q;
  logic       frame_tick;
  pat_e       pat_q;
  logic [9:0] box_x;
  logic [8:0] box_y;
  logic       hit;
  rgb444      bg;

  logic       hit_p1;
  logic       blank_p1;
  logic       hs_p1;
  logic       vs_p1;
  rgb444      bg_p1;

  rgb444      rgb_p2;
  logic       hs_p2;
  logic       vs_p2;

  function automatic logic [3:0] sat_grad(input logic [3:0] v);
    return (v > 4'd9) ? 4'd9 : v;
  endfunction

  // Ticks fall inside vertical blanking, so latching pattern/position here never tears.
  assign frame_tick = vs_q & ~VSync_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_q  <= 1'b1;
      pat_q <= PAT_BLACK;
    end else begin
      vs_q <= VSync_in;
      if (frame_tick) pat_q <= pat_e'(pattern);
    end
  end

  vga_box_motion #(
    .BOX_SIZE (BOX_SIZE),
    .STEP     (STEP),
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_motion (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .box_x      (box_x),
    .box_y      (box_y)
  );

  always_comb begin
    bg = '0;
    case (pat_q)
      PAT_BARS: begin
        bg.r = {4{x[7]}};
        bg.g = {4{x[8]}};
        bg.b = {4{x[9]}};
      end
      PAT_GRAD: begin
        bg.r = sat_grad(x[9:6]);
        bg.g = y[8:5];
      end
      PAT_CHECK: bg = (x[5] ^ y[5]) ? rgb444'(12'hFFF) : rgb444'(12'h000);
      default:   bg = '0;
    endcase
  end

  assign hit = (x >= box_x) && ({1'b0, x} < ({1'b0, box_x} + 11'(BOX_SIZE))) &&
               (y >= box_y) && ({1'b0, y} < ({1'b0, box_y} + 10'(BOX_SIZE)));

  // Stage 1: hit flag, background colour, blanking and sync capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_p1   <= 1'b0;
      bg_p1    <= '0;
      blank_p1 <= 1'b1;
      hs_p1    <= 1'b1;
      vs_p1    <= 1'b1;
    end else begin
      hit_p1   <= hit;
      bg_p1    <= bg;
      blank_p1 <= blanking;
      hs_p1    <= HSync_in;
      vs_p1    <= VSync_in;
    end
  end

  // Stage 2: final colour select and sync outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_p2 <= '0;
      hs_p2  <= 1'b1;
      vs_p2  <= 1'b1;
    end else begin
      rgb_p2 <= blank_p1 ? rgb444'(12'h000) : (hit_p1 ? rgb444'(BOX_RGB) : bg_p1);
      hs_p2  <= hs_p1;
      vs_p2  <= vs_p1;
    end
  end

  assign vgaRed   = rgb_p2.r;
  assign vgaGreen = rgb_p2.g;
  assign vgaBlue  = rgb_p2.b;
  assign HSync    = hs_p2;
  assign VSync    = vs_p2;

endmodule
